imm_decode_stage: RTL and testbench
===================================

# imm_decode_stage

Registered immediate-decode pipeline stage between fetch and execute. Accepts raw instructions with their PC over a valid/ready handshake, extracts and sign-extends the immediate to XLEN, classifies the format and precomputes the PC-relative target. Buffers through a 2-entry skid buffer so backpressure never drops or duplicates an instruction. Supersedes the combinational 32-bit immediate generator in the decode path.

## Interface
- XLEN, 32, datapath width; legal values 32 or 64.
- clk  in  1  clock, all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  discard all buffered entries (branch redirect).
- in_valid  in  1  upstream instruction valid.
- in_ready  out  1  stage can accept an instruction this cycle.
- in_instr  in  32  raw instruction word.
- in_pc  in  XLEN  instruction address.
- out_valid  out  1  decoded entry available.
- out_ready  in  1  downstream accepts entry.
- out_imm  out  XLEN  extended immediate.
- out_fmt  out  3  format code (see Operation).
- out_pc  out  XLEN  PC of the entry.
- out_target  out  XLEN  out_pc + out_imm, modulo 2^XLEN.
- out_instr  out  32  raw instruction, passed through.

## Operation
- Format by opcode: 0010011/0000011/1100111 → I (1); 0100011 → S (2); 1100011 → B (3); 0110111/0010111 → U (4); 1101111 → J (5); 1110011 with instr[14]=1 → Z (6), config-dependent; all else → NONE (0), imm 0.
- I: instr[31:20] sign-extended. S: {instr[31:25],instr[11:7]} sign-extended. B: {instr[31],instr[7],instr[30:25],instr[11:8],0} sign-extended. J: {instr[31],instr[19:12],instr[20],instr[30:21],0} sign-extended. U: {instr[31:12],12'b0}, sign-extended from bit 31 to XLEN.
- Target computed for every format in the same cycle as extraction, registered with the entry; wraps at 2^XLEN.
- Storage: main output register plus one skid register. Accept when in_valid && in_ready. Entry moves to output register if empty or being consumed; otherwise to skid.
- When output consumed and skid full, skid moves to output the same edge; in_ready is then 1 next cycle.
- in_ready is registered: 1 iff skid empty.
- Order strictly preserved; no entry duplicated or lost without flush.
- flush: both entries invalidated at next edge; an in-cycle handshake on the input side is discarded; in_ready = 1 next cycle. flush overrides simultaneous accept and consume.

## Timing
- Latency: accepted at edge N → out_valid at edge N (visible cycle N+1) when output empty.
- Throughput: 1 per cycle with out_ready held high.
- Reset (async assert, sync release): out_valid 0, in_ready 1, out_imm 0, out_fmt 0, out_pc 0, out_target 0, out_instr 0 (NOP encoding not substituted), skid empty.
- Reset mid-transfer drops all entries; no output asserted until a new accept.
- out_* stable while out_valid && !out_ready.
- Simultaneous accept + consume with skid empty: new entry replaces output, skid stays empty.

## Configuration
- IMMGEN_ZIMM_EN defined: SYSTEM opcode with instr[14]=1 (CSRRWI/CSRRSI/CSRRCI) → fmt Z, imm = zero-extended instr[19:15].
- Not defined: such instructions → fmt NONE, imm 0; fmt code 6 never produced.

## Structure
- Shared package imm_pkg: format enum (NONE..Z, 3 bits), opcode constants, XLEN legality check.
- One combinational sub-module imm_extract (instr → imm, fmt, parametrised XLEN); imm_decode_stage holds handshake, skid buffer and target adder.

## Test plan
- XLEN=32, addi x1,x0,-1 (0xFFF00093), pc 0x100, out_ready=1 → next cycle out_imm 0xFFFFFFFF, fmt 1, target 0x000000FF.
- XLEN=64, lui 0x80000 (0x800000B7) → out_imm 0xFFFFFFFF80000000, fmt 4.
- beq offset -4 (0xFE000EE3), pc 0x0 → imm 0xFFFFFFFC, fmt 3, target wraps to 0xFFFFFFFC.
- Stream 4 instructions back-to-back, out_ready low 2 cycles mid-stream → in_ready drops 1 cycle after skid fills; all 4 emerge in order, none duplicated.
- Skid full, assert flush with in_valid=1 → next cycle out_valid 0, in_ready 1, flushed-cycle input never emerges.
- csrrwi (0x3400D073): with IMMGEN_ZIMM_EN → fmt 6, imm 1; without → fmt 0, imm 0. Async reset mid-stream → all outputs at reset values immediately.

Source files
------------

// File: rtl/imm_pkg.sv
// Shared definitions for the immediate-decode stage: format codes, RV opcodes, XLEN check.
// Optional feature macro: IMMGEN_ZIMM_EN (CSR immediate forms decode as format Z).
package imm_pkg;

    typedef enum logic [2:0] {
        FMT_NONE = 3'd0,
        FMT_I    = 3'd1,
        FMT_S    = 3'd2,
        FMT_B    = 3'd3,
        FMT_U    = 3'd4,
        FMT_J    = 3'd5,
        FMT_Z    = 3'd6
    } fmt_e;

    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    function automatic bit xlen_legal(input int xlen);
        return (xlen == 32) || (xlen == 64);
    endfunction

endpackage

// File: rtl/imm_extract.sv
// Combinational immediate extraction and format classification for one instruction word.
// Optional feature macro: IMMGEN_ZIMM_EN (CSRRxI zimm is reported as format Z).
module imm_extract
    import imm_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     i_instr,
    output logic [XLEN-1:0] o_imm,
    output fmt_e            o_fmt
);

    logic [31:0] w_imm32;

    // Every format fits in 32 bits, so it is built there and widened by replicating bit 31.
    always_comb begin
        w_imm32 = 32'h0;
        o_fmt   = FMT_NONE;
        unique case (i_instr[6:0])
            OPC_OP_IMM, OPC_LOAD, OPC_JALR: begin
                o_fmt   = FMT_I;
                w_imm32 = {{20{i_instr[31]}}, i_instr[31:20]};
            end
            OPC_STORE: begin
                o_fmt   = FMT_S;
                w_imm32 = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
            end
            OPC_BRANCH: begin
                o_fmt   = FMT_B;
                w_imm32 = {{19{i_instr[31]}}, i_instr[31], i_instr[7],
                           i_instr[30:25], i_instr[11:8], 1'b0};
            end
            OPC_LUI, OPC_AUIPC: begin
                o_fmt   = FMT_U;
                w_imm32 = {i_instr[31:12], 12'h000};
            end
            OPC_JAL: begin
                o_fmt   = FMT_J;
                w_imm32 = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12],
                           i_instr[20], i_instr[30:21], 1'b0};
            end
`ifdef IMMGEN_ZIMM_EN
            OPC_SYSTEM: begin
                if (i_instr[14]) begin
                    o_fmt   = FMT_Z;
                    w_imm32 = {27'h0, i_instr[19:15]};
                end
            end
`endif
            default: begin
                o_fmt   = FMT_NONE;
                w_imm32 = 32'h0;
            end
        endcase
        o_imm       = {XLEN{w_imm32[31]}};
        o_imm[31:0] = w_imm32;
    end

endmodule

// File: rtl/imm_decode_stage.sv
// Registered immediate-decode stage with a 2-entry skid buffer and PC-relative target adder.
// Optional feature macro: IMMGEN_ZIMM_EN (forwarded to imm_extract).
module imm_decode_stage
    import imm_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_fmt,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_target,
    output logic [31:0]     out_instr
);

    typedef struct packed {
        logic [31:0]     instr;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] target;
        logic [XLEN-1:0] imm;
        fmt_e            fmt;
    } entry_t;

    if (!xlen_legal(XLEN)) begin : g_bad_xlen
        $error("imm_decode_stage: XLEN must be 32 or 64");
    end

    logic [XLEN-1:0] w_imm;
    fmt_e            w_fmt;
    entry_t          w_new;
    logic            w_accept;
    logic            w_consume;
    entry_t          w_outNext;
    entry_t          w_skidNext;
    logic            w_outValidNext;
    logic            w_skidValidNext;

    entry_t          r_out;
    entry_t          r_skid;
    logic            r_outValid;
    logic            r_skidValid;
    logic            r_inReady;

    imm_extract #(.XLEN(XLEN)) u_extract (
        .i_instr (in_instr),
        .o_imm   (w_imm),
        .o_fmt   (w_fmt)
    );

    assign w_accept  = in_valid && r_inReady;
    assign w_consume = r_outValid && out_ready;

    always_comb begin
        w_new.instr  = in_instr;
        w_new.pc     = in_pc;
        w_new.target = in_pc + w_imm;
        w_new.imm    = w_imm;
        w_new.fmt    = w_fmt;
    end

    // in_ready is only high while the skid is empty, so an accept never coincides with a skid drain.
    always_comb begin
        w_outNext       = r_out;
        w_skidNext      = r_skid;
        w_outValidNext  = r_outValid;
        w_skidValidNext = r_skidValid;
        if (flush) begin
            w_outValidNext  = 1'b0;
            w_skidValidNext = 1'b0;
        end else if (!r_outValid || w_consume) begin
            if (r_skidValid) begin
                w_outNext       = r_skid;
                w_outValidNext  = 1'b1;
                w_skidValidNext = 1'b0;
            end else if (w_accept) begin
                w_outNext      = w_new;
                w_outValidNext = 1'b1;
            end else begin
                w_outValidNext = 1'b0;
            end
        end else if (w_accept) begin
            w_skidNext      = w_new;
            w_skidValidNext = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out       <= '0;
            r_skid      <= '0;
            r_outValid  <= 1'b0;
            r_skidValid <= 1'b0;
            r_inReady   <= 1'b1;
        end else begin
            r_out       <= w_outNext;
            r_skid      <= w_skidNext;
            r_outValid  <= w_outValidNext;
            r_skidValid <= w_skidValidNext;
            r_inReady   <= !w_skidValidNext;
        end
    end

    assign in_ready   = r_inReady;
    assign out_valid  = r_outValid;
    assign out_imm    = r_out.imm;
    assign out_fmt    = r_out.fmt;
    assign out_pc     = r_out.pc;
    assign out_target = r_out.target;
    assign out_instr  = r_out.instr;

endmodule

// File: tb/tb_imm_decode_stage.sv
// Self-checking bench for imm_decode_stage: scoreboard on an XLEN=32 instance plus directed XLEN=64 checks.
// Honours IMMGEN_ZIMM_EN when building expectations for CSR immediate instructions.
module tb_imm_decode_stage;

    typedef struct {
        logic [31:0] imm;
        logic [2:0]  fmt;
        logic [31:0] pc;
        logic [31:0] target;
        logic [31:0] instr;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_imm;
    logic [2:0]  out_fmt;
    logic [31:0] out_pc;
    logic [31:0] out_target;
    logic [31:0] out_instr;

    logic        flush64;
    logic        in_valid64;
    logic        in_ready64;
    logic [31:0] in_instr64;
    logic [63:0] in_pc64;
    logic        out_valid64;
    logic        out_ready64;
    logic [63:0] out_imm64;
    logic [2:0]  out_fmt64;
    logic [63:0] out_pc64;
    logic [63:0] out_target64;
    logic [31:0] out_instr64;

    int   compared = 0;
    int   mismatched = 0;
    int   readyLowCount = 0;
    bit   streamActive = 1'b0;
    bit   driveDone = 1'b0;
    exp_t sb[$];

    always #5 clk = ~clk;

    imm_decode_stage #(.XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_imm(out_imm), .out_fmt(out_fmt),
        .out_pc(out_pc), .out_target(out_target), .out_instr(out_instr)
    );

    imm_decode_stage #(.XLEN(64)) dut64 (
        .clk(clk), .rst_n(rst_n), .flush(flush64),
        .in_valid(in_valid64), .in_ready(in_ready64), .in_instr(in_instr64), .in_pc(in_pc64),
        .out_valid(out_valid64), .out_ready(out_ready64), .out_imm(out_imm64), .out_fmt(out_fmt64),
        .out_pc(out_pc64), .out_target(out_target64), .out_instr(out_instr64)
    );

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, wanted 0x%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [63:0] refImm(input logic [31:0] i);
        logic [63:0] r;
        r = 64'h0;
        case (i[6:0])
            7'b0010011, 7'b0000011, 7'b1100111: r = {{52{i[31]}}, i[31:20]};
            7'b0100011: r = {{52{i[31]}}, i[31:25], i[11:7]};
            7'b1100011: r = {{51{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
            7'b0110111, 7'b0010111: r = {{32{i[31]}}, i[31:12], 12'h000};
            7'b1101111: r = {{43{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
`ifdef IMMGEN_ZIMM_EN
            7'b1110011: if (i[14]) r = {59'h0, i[19:15]};
`endif
            default: r = 64'h0;
        endcase
        return r;
    endfunction

    function automatic logic [2:0] refFmt(input logic [31:0] i);
        case (i[6:0])
            7'b0010011, 7'b0000011, 7'b1100111: return 3'd1;
            7'b0100011: return 3'd2;
            7'b1100011: return 3'd3;
            7'b0110111, 7'b0010111: return 3'd4;
            7'b1101111: return 3'd5;
`ifdef IMMGEN_ZIMM_EN
            7'b1110011: return i[14] ? 3'd6 : 3'd0;
`endif
            default: return 3'd0;
        endcase
    endfunction

    function automatic exp_t refEntry(input logic [31:0] i, input logic [31:0] pc);
        exp_t e;
        logic [63:0] imm64;
        imm64    = refImm(i);
        e.imm    = imm64[31:0];
        e.fmt    = refFmt(i);
        e.pc     = pc;
        e.target = pc + imm64[31:0];
        e.instr  = i;
        return e;
    endfunction

    // Handshakes are judged mid-cycle, when inputs and registered outputs are both settled for the next edge.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n || flush) begin
            sb.delete();
        end else begin
            if (streamActive && !in_ready) readyLowCount++;
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    checkOutput("sbUnderflow", 64'd1, 64'd0);
                end else begin
                    e = sb.pop_front();
                    checkOutput("sbImm", {32'h0, out_imm}, {32'h0, e.imm});
                    checkOutput("sbFmt", {61'h0, out_fmt}, {61'h0, e.fmt});
                    checkOutput("sbPc", {32'h0, out_pc}, {32'h0, e.pc});
                    checkOutput("sbTarget", {32'h0, out_target}, {32'h0, e.target});
                    checkOutput("sbInstr", {32'h0, out_instr}, {32'h0, e.instr});
                end
            end
            if (in_valid && in_ready) sb.push_back(refEntry(in_instr, in_pc));
        end
    end

    // Called just after a rising edge; holds the request until it is taken, bounded by a cycle budget.
    task automatic applyStimulus(input logic [31:0] instr, input logic [31:0] pc);
        in_valid = 1'b1;
        in_instr = instr;
        in_pc    = pc;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk);
                #1;
                in_valid = 1'b0;
                return;
            end
        end
        checkOutput("handshakeTimeout", 64'd0, 64'd1);
        in_valid = 1'b0;
    endtask

    task automatic singleCheck(input string tag, input logic [31:0] instr, input logic [31:0] pc,
                               input logic [31:0] expImm, input logic [2:0] expFmt, input logic [31:0] expTarget);
        applyStimulus(instr, pc);
        @(negedge clk);
        checkOutput({tag, "Valid"}, {63'h0, out_valid}, 64'd1);
        checkOutput({tag, "Imm"}, {32'h0, out_imm}, {32'h0, expImm});
        checkOutput({tag, "Fmt"}, {61'h0, out_fmt}, {61'h0, expFmt});
        checkOutput({tag, "Target"}, {32'h0, out_target}, {32'h0, expTarget});
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout, wanted completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] rnd;
        logic [6:0]  ops [10];
        bit          seen;
        ops = '{7'b0010011, 7'b0000011, 7'b1100111, 7'b0100011, 7'b1100011,
                7'b0110111, 7'b0010111, 7'b1101111, 7'b1110011, 7'b0110011};

        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_instr = 32'h0; in_pc = 32'h0; out_ready = 1'b0;
        flush64 = 1'b0; in_valid64 = 1'b0; in_instr64 = 32'h0; in_pc64 = 64'h0; out_ready64 = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("rstOutValid", {63'h0, out_valid}, 64'd0);
        checkOutput("rstInReady", {63'h0, in_ready}, 64'd1);
        checkOutput("rstImm", {32'h0, out_imm}, 64'd0);
        checkOutput("rstFmt", {61'h0, out_fmt}, 64'd0);
        checkOutput("rstPc", {32'h0, out_pc}, 64'd0);
        checkOutput("rstTarget", {32'h0, out_target}, 64'd0);
        checkOutput("rstInstr", {32'h0, out_instr}, 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        out_ready = 1'b1;
        singleCheck("addi", 32'hFFF00093, 32'h100, 32'hFFFFFFFF, 3'd1, 32'h000000FF);
        singleCheck("beq", 32'hFE000EE3, 32'h0, 32'hFFFFFFFC, 3'd3, 32'hFFFFFFFC);
`ifdef IMMGEN_ZIMM_EN
        singleCheck("csrrwi", 32'h3400D073, 32'h40, 32'h1, 3'd6, 32'h41);
`else
        singleCheck("csrrwi", 32'h3400D073, 32'h40, 32'h0, 3'd0, 32'h40);
`endif

        in_valid64 = 1'b1; in_instr64 = 32'h800000B7; in_pc64 = 64'h1000;
        @(posedge clk);
        #1;
        in_valid64 = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 10 && !seen; k++) begin
            @(negedge clk);
            seen = out_valid64;
        end
        checkOutput("lui64Valid", {63'h0, seen}, 64'd1);
        checkOutput("lui64Imm", out_imm64, 64'hFFFFFFFF80000000);
        checkOutput("lui64Fmt", {61'h0, out_fmt64}, 64'd4);
        checkOutput("lui64Target", out_target64, 64'hFFFFFFFF80001000);
        @(posedge clk);
        #1;

        readyLowCount = 0;
        streamActive = 1'b1;
        fork
            begin
                for (int n = 0; n < 4; n++) applyStimulus(32'h00A00093 + (n << 20), 32'h200 + 4 * n);
            end
            begin
                @(posedge clk);
                #1;
                out_ready = 1'b0;
                repeat (2) @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        streamActive = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("streamReadyLow", readyLowCount, 64'd2);
        @(negedge clk);
        checkOutput("streamDrain", sb.size(), 64'd0);
        @(posedge clk);
        #1;

        out_ready = 1'b0;
        applyStimulus(32'h00100113, 32'h300);
        applyStimulus(32'h00200113, 32'h304);
        in_valid = 1'b1; in_instr = 32'h00300113; in_pc = 32'h308; flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        checkOutput("flushOutValid", {63'h0, out_valid}, 64'd0);
        checkOutput("flushInReady", {63'h0, in_ready}, 64'd1);
        out_ready = 1'b1;
        seen = 1'b0;
        repeat (3) begin
            @(negedge clk);
            seen = seen | out_valid;
        end
        checkOutput("flushNothingEmerges", {63'h0, seen}, 64'd0);
        @(posedge clk);
        #1;

        driveDone = 1'b0;
        fork
            begin
                for (int n = 0; n < 40; n++) begin
                    rnd = $urandom();
                    if ($urandom_range(0, 3) == 0) begin
                        @(posedge clk);
                        #1;
                    end
                    applyStimulus({rnd[31:7], ops[$urandom_range(0, 9)]}, $urandom());
                end
                driveDone = 1'b1;
            end
            begin
                while (!driveDone) begin
                    out_ready = ($urandom_range(0, 3) != 0);
                    @(posedge clk);
                    #1;
                end
            end
        join
        out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        @(negedge clk);
        checkOutput("randomDrain", sb.size(), 64'd0);
        @(posedge clk);
        #1;

        out_ready = 1'b0;
        applyStimulus(32'h12345037, 32'h400);
        applyStimulus(32'h00500113, 32'h404);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("asyncRstOutValid", {63'h0, out_valid}, 64'd0);
        checkOutput("asyncRstInReady", {63'h0, in_ready}, 64'd1);
        checkOutput("asyncRstImm", {32'h0, out_imm}, 64'd0);
        checkOutput("asyncRstInstr", {32'h0, out_instr}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        seen = 1'b0;
        repeat (3) begin
            @(negedge clk);
            seen = seen | out_valid;
        end
        checkOutput("postRstIdle", {63'h0, seen}, 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
